// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU, iterative MULU and (with ALU_MC_DIV_EN defined) DIVU
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             brancheq,
    input  logic             notor,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zout,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] mcand, res, hv;
    logic [2*WIDTH-1:0] prod, step;
    logic [WIDTH:0] add_t;
    logic slt, br, zbr, zf, ill, multi, go;
`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0] sub_t;
    logic is_div;
`endif
    assign busy = state == RUN;
    assign go = start && state == IDLE;
    always_comb begin
        res = '0;
        hv = '0;
        br = 1'b0;
        zbr = 1'b0;
        ill = 1'b0;
        multi = 1'b0;
        slt = $signed(a) < $signed(b);
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = notor ? ~(a | b) : a | b;
            4'b0010: res = a + b;
            4'b0110: res = a - b;
            4'b0111: res = {{(WIDTH-1){1'b0}}, slt};
            4'b0011: begin res = a; br = 1'b1; zbr = |(a - b); end
            4'b0100: begin res = a; br = 1'b1; zbr = brancheq ? ~a[WIDTH-1] : ~a[WIDTH-1] & |a; end
            4'b0101: begin res = a; br = 1'b1; zbr = a[WIDTH-1] | (brancheq & ~|a); end
            4'b1000: multi = 1'b1;
`ifdef ALU_MC_DIV_EN
            4'b1001: begin
                if (b == '0) begin
                    res = '1;
                    hv = a;
                end else begin
                    multi = 1'b1;
                end
            end
`endif
            default: ill = 1'b1;
        endcase
        zf = br ? zbr : ~|res;
    end
    // prod holds {acc, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        add_t = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
        step = {add_t, prod[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        sub_t = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {1'b0, mcand};
        if (is_div)
            step = sub_t[WIDTH] ? {prod[2*WIDTH-2:0], 1'b0} : {sub_t[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
`endif
    end
    always_comb begin
        state_n = state;
        if (go && multi) state_n = RUN;
        else if (busy && cnt == LAST) state_n = IDLE;
    end
    always_ff @(posedge clk) state <= reset ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
            result <= '0;
            hi <= '0;
            zout <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go && multi) begin
                prod <= {{WIDTH{1'b0}}, a};
                mcand <= b;
                cnt <= '0;
`ifdef ALU_MC_DIV_EN
                is_div <= op[0];
`endif
            end else if (go) begin
                result <= res;
                hi <= hv;
                zout <= zf;
                illegal <= ill;
                done <= 1'b1;
            end else if (busy) begin
                prod <= step;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    result <= step[WIDTH-1:0];
                    hi <= step[2*WIDTH-1:WIDTH];
                    zout <= ~|step[WIDTH-1:0];
                    illegal <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule
